// File: rtl/sub_pipe_pkg.sv
// Shared widths and the zero-extension helper for the pipelined subtractor.
package sub_pipe_pkg;

  localparam int unsigned IN_W_DEF  = 14;
  localparam int unsigned OUT_W_DEF = 17;

  // Widest value the helper handles; callers size-cast the result to their OUT_W.
  localparam int unsigned ZEXT_W = 64;

  // Keep only the low src_w bits so any upper garbage can never leak into the sign.
  function automatic logic [ZEXT_W-1:0] zext_to_out(input logic [ZEXT_W-1:0] v,
                                                   input int unsigned      src_w);
    logic [ZEXT_W-1:0] mask;
    if (src_w >= ZEXT_W) begin
      mask = '1;
    end else begin
      mask = (ZEXT_W'(1) << src_w) - ZEXT_W'(1);
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/sub_stage.sv
// One registered subtract stage: diff <= minuend - zext(subtrahend), with a
// passthrough sideband, a valid bit and a hold enable.
module sub_stage
  import sub_pipe_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned SUB_W = IN_W_DEF,
  parameter int unsigned SB_W  = 0,
  localparam int unsigned SbPortW = (SB_W > 0) ? SB_W : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [OUT_W-1:0]   minuend,
  input  logic [SUB_W-1:0]   subtrahend,
  input  logic [SbPortW-1:0] sb_in,
  output logic               out_valid,
  output logic [OUT_W-1:0]   diff,
  output logic [SbPortW-1:0] sb_out
);

  logic [OUT_W-1:0] sub_ext;
  logic [OUT_W-1:0] diff_d;
  logic [OUT_W-1:0] diff_q;
  logic             valid_q;

  assign sub_ext = OUT_W'(zext_to_out(ZEXT_W'(subtrahend), SUB_W));
  assign diff_d  = minuend - sub_ext;

  // Data also moves on bubbles; only the valid bit distinguishes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      diff_q  <= '0;
    end else if (en) begin
      valid_q <= in_valid;
      diff_q  <= diff_d;
    end
  end

  assign out_valid = valid_q;
  assign diff      = diff_q;

  generate
    if (SB_W > 0) begin : g_sb
      logic [SbPortW-1:0] sb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sb_q <= '0;
        end else if (en) begin
          sb_q <= sb_in;
        end
      end

      assign sb_out = sb_q;
    end else begin : g_no_sb
      logic unused_sb;

      assign unused_sb = ^sb_in;
      assign sb_out    = '0;
    end
  endgenerate

endmodule

// File: rtl/sub_pipe4.sv
// Pipelined 4-operand subtractor (in1 - in2 - in3 - in4) with valid/ready and a
// global stall. Define SUB_PIPE4_SAT_EN to clamp negative results to 0 and add sat_hit.
module sub_pipe4
  import sub_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = IN_W + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic [IN_W-1:0]  in3,
  input  logic [IN_W-1:0]  in4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             neg
`ifdef SUB_PIPE4_SAT_EN
  ,
  output logic             sat_hit
`endif
);

  logic                stall;
  logic                adv;
  logic [OUT_W-1:0]    in1_ext;

  logic                v1;
  logic [OUT_W-1:0]    d1;
  logic [2*IN_W-1:0]   sb1;

  logic                v2;
  logic [OUT_W-1:0]    d2;
  logic [IN_W-1:0]     sb2;

  logic                v3;
  logic [OUT_W-1:0]    d3;
  logic                s3_sb_unused;

  // A bubble in S3 never stalls, so the whole pipe only freezes on a refused result.
  assign stall    = v3 && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  assign in1_ext = OUT_W'(zext_to_out(ZEXT_W'(in1), IN_W));

  // S1 carries {in3, in4} so each later subtrahend belongs to the same set.
  sub_stage #(
    .OUT_W (OUT_W),
    .SUB_W (IN_W),
    .SB_W  (2 * IN_W)
  ) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (adv),
    .in_valid   (in_valid),
    .minuend    (in1_ext),
    .subtrahend (in2),
    .sb_in      ({in3, in4}),
    .out_valid  (v1),
    .diff       (d1),
    .sb_out     (sb1)
  );

  sub_stage #(
    .OUT_W (OUT_W),
    .SUB_W (IN_W),
    .SB_W  (IN_W)
  ) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (adv),
    .in_valid   (v1),
    .minuend    (d1),
    .subtrahend (sb1[2*IN_W-1:IN_W]),
    .sb_in      (sb1[IN_W-1:0]),
    .out_valid  (v2),
    .diff       (d2),
    .sb_out     (sb2)
  );

  sub_stage #(
    .OUT_W (OUT_W),
    .SUB_W (IN_W),
    .SB_W  (0)
  ) u_s3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (adv),
    .in_valid   (v2),
    .minuend    (d2),
    .subtrahend (sb2),
    .sb_in      (1'b0),
    .out_valid  (v3),
    .diff       (d3),
    .sb_out     (s3_sb_unused)
  );

  assign out_valid = v3;
  assign neg       = d3[OUT_W-1];

`ifdef SUB_PIPE4_SAT_EN
  // Clamp is applied to the held S3 register, so out stays stable during a stall.
  always_comb begin
    out = d3;
    if (d3[OUT_W-1]) begin
      out = '0;
    end
  end

  assign sat_hit = v3 && out_ready && d3[OUT_W-1];
`else
  assign out = d3;
`endif

endmodule
